// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, register index width, NOP encoding.
package core_pkg;
    localparam int          REG_IDX_W = 5;
    localparam int          MD_CNT_W  = 4;            // holds MD_LAT-2 for MD_LAT up to 15
    localparam logic [31:0] NOP       = 32'h00000013; // addi x0, x0, 0

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;
endpackage

// File: rtl/md_stall_timer.sv
// Loadable down-counter sequencing the MD_BUSY phase of a multi-cycle EX op.
// md_cnt is loaded with MD_LAT-2, the number of MD_BUSY cycles that follow the
// first occupancy cycle; busy stays high while more than the current MD_BUSY
// cycle remains, so the owner leaves MD_BUSY on the cycle busy drops.
module md_stall_timer
    import core_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic busy
);
    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LAT - 2);

    logic [MD_CNT_W-1:0] md_cnt;

    // load on MD issue, count down once per MD_BUSY cycle, park at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        md_cnt <= '0;
        else if (load)                   md_cnt <= LOAD_VAL;
        else if (dec && md_cnt != '0)    md_cnt <= md_cnt - 1'b1;
    end

    assign busy = (md_cnt > MD_CNT_W'(1));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX jump/branch flush and
// multi-cycle MUL/DIV stall for the F/D/E pipeline registers.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] d_rs1,
    input  logic [REG_IDX_W-1:0] d_rs2,
    input  logic                 d_use_rs1,
    input  logic                 d_use_rs2,
    input  logic [REG_IDX_W-1:0] e_rd,
    input  logic                 e_is_load,
    input  logic                 e_is_md,
    input  logic                 e_jb,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 jb_d,
    output logic                 flush_e,
    output logic                 stall_e,
    output logic                 md_busy,
    output logic [CNT_W-1:0]     stall_cyc,
    output logic [CNT_W-1:0]     flush_cnt
);
    hz_state_e state;
    logic      load_use;
    logic      md_start;
    logic      tmr_busy;

    assign load_use = e_is_load && (e_rd != '0) &&
                      ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    assign md_start = (state == RUN) && e_is_md;

    md_stall_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk  (clk),
        .rst  (rst),
        .load (md_start),
        .dec  (state == MD_BUSY),
        .busy (tmr_busy)
    );

    // FSM: MD issue enters MD_BUSY unless the op needs only the issue-cycle stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (e_is_md && MD_LAT > 2) state <= MD_BUSY;
                MD_BUSY: if (!tmr_busy)             state <= RUN;
                default:                            state <= RUN;
            endcase
        end
    end

    // control outputs by priority; forced low while reset is asserted
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        jb_d    = 1'b0;
        flush_e = 1'b0;
        stall_e = 1'b0;
        md_busy = 1'b0;
        if (rst) begin
            if (state == MD_BUSY || e_is_md) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                md_busy = 1'b1;
            end else if (e_jb) begin
                // younger instruction in D is squashed, so a load-use match is moot
                jb_d    = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] sc_q;
    logic [CNT_W-1:0] fc_q;

    // saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_q <= '0;
            fc_q <= '0;
        end else begin
            if (stall_f && !(&sc_q)) sc_q <= sc_q + 1'b1;
            if (jb_d    && !(&fc_q)) fc_q <= fc_q + 1'b1;
        end
    end

    assign stall_cyc = sc_q;
    assign flush_cnt = fc_q;
`else
    assign stall_cyc = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    typedef struct {
        logic       md, jb, ld;
        logic [4:0] rd, r1, r2;
        logic       u1, u2;
    } stim_t;

    logic clk, rst;
    logic [4:0] d_rs1, d_rs2, e_rd;
    logic d_use_rs1, d_use_rs2, e_is_load, e_is_md, e_jb;
    logic stall_f, stall_d, jb_d, flush_e, stall_e, md_busy;
    logic [CNT_W-1:0] stall_cyc, flush_cnt;
    logic [5:0] outs;

    assign outs = {stall_f, stall_d, jb_d, flush_e, stall_e, md_busy};

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rd(e_rd), .e_is_load(e_is_load), .e_is_md(e_is_md), .e_jb(e_jb),
        .stall_f(stall_f), .stall_d(stall_d), .jb_d(jb_d), .flush_e(flush_e),
        .stall_e(stall_e), .md_busy(md_busy),
        .stall_cyc(stall_cyc), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model: remaining MD stall cycles after the current one, event counts
    int md_rem = 0;
    int m_sc = 0;
    int m_fc = 0;
    logic [5:0] exp_o;
    int exp_sc, exp_fc;

    // apply one cycle of inputs and derive the expected outputs from the rules
    task automatic drive(input stim_t s);
        logic lu;
        e_is_md = s.md; e_jb = s.jb; e_is_load = s.ld; e_rd = s.rd;
        d_rs1 = s.r1; d_rs2 = s.r2; d_use_rs1 = s.u1; d_use_rs2 = s.u2;
        lu = s.ld && s.rd != 0 && ((s.u1 && s.r1 == s.rd) || (s.u2 && s.r2 == s.rd));
        if (md_rem > 0 || s.md) exp_o = 6'b110011;
        else if (s.jb)          exp_o = 6'b001100;
        else if (lu)            exp_o = 6'b110100;
        else                    exp_o = 6'b000000;
        exp_sc = m_sc;
        exp_fc = m_fc;
    endtask

    // advance the model across a clock edge
    task automatic tick();
`ifdef HAZARD_PERF_CNT_EN
        if (exp_o[5] && m_sc < MAXC) m_sc++;
        if (exp_o[3] && m_fc < MAXC) m_fc++;
`endif
        if (md_rem > 0)    md_rem--;
        else if (e_is_md)  md_rem = MD_LAT - 2;
    endtask

    function automatic stim_t mk(input logic md, jb, ld, input int rd, r1, r2,
                                 input logic u1, u2);
        stim_t s;
        s.md = md; s.jb = jb; s.ld = ld;
        s.rd = 5'(rd); s.r1 = 5'(r1); s.r2 = 5'(r2);
        s.u1 = u1; s.u2 = u2;
        return s;
    endfunction

    task automatic test_reset();
        rst = 0;
        drive(mk(1, 1, 1, 5, 5, 0, 1, 0));
        #1;
        nvec++;
        if (outs !== 6'b0 || stall_cyc !== '0 || flush_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_async outs=%b exp=000000 sc=%0d fc=%0d", outs, stall_cyc, flush_cnt);
        end
        @(posedge clk); #1;
        nvec++;
        if (outs !== 6'b0 || stall_cyc !== '0 || flush_cnt !== '0) begin
            nerr++;
            $display("FAIL reset_held outs=%b exp=000000 sc=%0d fc=%0d", outs, stall_cyc, flush_cnt);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1;
        md_rem = 0; m_sc = 0; m_fc = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t v[6];
        v[0] = mk(0, 0, 1, 5, 5, 0, 1, 0);   // rs1 match -> one stall
        v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);   // bubble in E -> no repeat
        v[2] = mk(0, 0, 1, 0, 0, 0, 1, 1);   // x0 never stalls
        v[3] = mk(0, 0, 1, 7, 3, 7, 0, 1);   // rs2 match
        v[4] = mk(0, 0, 1, 7, 7, 7, 0, 0);   // index match but not read
        v[5] = mk(0, 0, 0, 9, 9, 9, 1, 1);   // not a load
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL load_use[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    task automatic test_branch();
        stim_t v[4];
        v[0] = mk(0, 1, 1, 5, 5, 0, 1, 0);   // branch wins over load-use
        v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[2] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        v[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL branch[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    task automatic test_md();
        stim_t v[5];
        v[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);   // issue cycle stalls
        v[1] = mk(0, 1, 0, 0, 0, 0, 0, 0);   // branch ignored while busy
        v[2] = mk(0, 1, 1, 5, 5, 0, 1, 0);
        v[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);   // released after MD_LAT-1 cycles
        v[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL md[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t v[9];
        v[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[3] = mk(0, 0, 1, 6, 6, 0, 1, 0);   // dependent load right after MD
        v[4] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[5] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        v[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[7] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[8] = mk(1, 0, 0, 0, 0, 0, 0, 0);   // second MD immediately after first
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL b2b[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge clk); tick(); #1;
        end
    endtask

    task automatic test_reset_mid_md();
        stim_t v[2];
        v[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o) begin
                nerr++;
                $display("FAIL rst_md_pre[%0d] outs=%b exp=%b", i, outs, exp_o);
            end
            @(posedge clk); tick(); #1;
        end
        drive(mk(0, 1, 0, 0, 0, 0, 0, 0));
        #2;
        nvec++;
        if (outs !== exp_o) begin
            nerr++;
            $display("FAIL rst_md_busy outs=%b exp=%b", outs, exp_o);
        end
        rst = 0;
        #1;
        nvec++;
        if (outs !== 6'b0 || stall_cyc !== '0 || flush_cnt !== '0) begin
            nerr++;
            $display("FAIL rst_md_abort outs=%b exp=000000 sc=%0d fc=%0d", outs, stall_cyc, flush_cnt);
        end
        @(posedge clk); #1;
        md_rem = 0; m_sc = 0; m_fc = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1;
        @(posedge clk); #1;
        v[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);   // back in RUN, no leftover stall
        v[1] = mk(0, 0, 1, 4, 0, 4, 0, 1);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL rst_md_post[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    // 3-cycle MD stall + 1 load-use + 2 branches from a clean reset: 4 stalls, 2 flushes
    task automatic test_perf();
        stim_t v[8];
        test_reset();
        v[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        v[1] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[2] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[3] = mk(0, 0, 1, 2, 2, 0, 1, 0);
        v[4] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        v[5] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        v[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        v[7] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL perf[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    // random traffic; long enough to drive the narrow counters into saturation
    task automatic test_random();
        stim_t s;
        for (int i = 0; i < 400; i++) begin
            s.md = ($urandom_range(0, 9) == 0);
            s.jb = ($urandom_range(0, 4) == 0);
            s.ld = $urandom_range(0, 1);
            s.rd = 5'($urandom_range(0, 3));
            s.r1 = 5'($urandom_range(0, 3));
            s.r2 = 5'($urandom_range(0, 3));
            s.u1 = $urandom_range(0, 1);
            s.u2 = $urandom_range(0, 1);
            drive(s);
            @(negedge clk);
            nvec++;
            if (outs !== exp_o || stall_cyc !== CNT_W'(exp_sc) || flush_cnt !== CNT_W'(exp_fc)) begin
                nerr++;
                $display("FAIL random[%0d] outs=%b exp=%b sc=%0d/%0d fc=%0d/%0d",
                         i, outs, exp_o, stall_cyc, exp_sc, flush_cnt, exp_fc);
            end
            @(posedge clk); tick(); #1;
        end
    endtask

    initial begin
        clk = 0;
        rst = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_md();
        test_back_to_back();
        test_reset_mid_md();
        test_perf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
